mult32_seq: RTL and testbench
=============================

MULT32_SEQ -- requirements
Module: mult32_seq

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  block can accept a request.
REQ-006 req_op  in  2  operation: 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
REQ-007 req_a, req_b  in  32 each  multiplicand and multiplier.
REQ-008 kill  in  1  pipeline flush; abandons any in-flight operation.
REQ-009 resp_valid  out  1  result available.
REQ-010 resp_ready  in  1  consumer accepts result.
REQ-011 resp_data  out  32  result: low word of the product for MUL, high word otherwise.
REQ-012 busy  out  1  high whenever the state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE; req_ready SHALL equal (state==IDLE).
REQ-014 Accept SHALL occur when req_valid & req_ready & ~kill at an edge; the block latches operands and op, clears the 64-bit accumulator and step to 0, and enters CALC.
REQ-015 Operand split SHALL be: low halves zero-extended to 17 bits; high halves sign-extended from bit 31 if that operand is signed, else zero-extended.
REQ-016 Signedness SHALL be: MUL and MULH both signed; MULHSU a signed, b unsigned; MULHU both unsigned.
REQ-017 CALC SHALL perform one 17x17 signed product per cycle, in step order:
- step 0: AL*BL, shift 0
- step 1: AL*BH, shift 16
- step 2: AH*BL, shift 16
- step 3: AH*BH, shift 32
REQ-018 Each product SHALL be sign-extended, shifted and added into the accumulator modulo 2^64.
REQ-019 After step 3 the FSM SHALL enter DONE; for an accept in cycle N, resp_valid SHALL first be high in cycle N+5.
REQ-020 In DONE, resp_valid=1 and resp_data SHALL stay stable until resp_valid & resp_ready, then the FSM SHALL return to IDLE.
REQ-021 kill SHALL force IDLE at the next edge from any state: resp_valid goes low, the result is discarded, and any request in the same cycle is not accepted.
REQ-022 kill coinciding with resp_ready in DONE SHALL count as a completed transfer and leave the FSM in IDLE.
REQ-023 req_valid while not ready SHALL be ignored; the requester holds it.

Reset
REQ-024 On rst the FSM SHALL enter IDLE and step, accumulator and latched operands SHALL clear to 0.
REQ-025 Output values during reset SHALL be: resp_valid=0, resp_data=0, busy=0, req_ready=1 from the cycle after rst deasserts.
REQ-026 rst during CALC or DONE SHALL abandon the operation with no response.
REQ-027 rst SHALL override kill and all requests.

Configuration
REQ-028 With macro MULT_RESULT_REUSE_EN defined, the block SHALL hold a tag {a, b, a_signed, b_signed, valid} and the last 64-bit product, both updated on entry to DONE from CALC.
REQ-029 With MULT_RESULT_REUSE_EN defined, an accepted request matching a valid tag SHALL go IDLE->DONE directly and give resp_valid in cycle N+1.
REQ-030 With MULT_RESULT_REUSE_EN defined, rst SHALL clear the tag valid bit.
REQ-031 With MULT_RESULT_REUSE_EN defined, kill during CALC SHALL leave the tag unchanged.
REQ-032 Without MULT_RESULT_REUSE_EN, no tag storage SHALL exist and every request SHALL take the full CALC path.

Structure
REQ-033 Shared package mult_pkg SHALL hold the op encodings, FSM state encoding, step count constant (4) and half width (17).
REQ-034 Sub-module mult17_booth SHALL be a combinational 17x17 signed radix-4 Booth multiplier giving a 34-bit product.
REQ-035 mult32_seq SHALL instantiate mult17_booth once and time-share it across the four steps.

Verification
REQ-036 MUL a=0x00000007, b=0xFFFFFFFD -> resp_data=0xFFFFFFEB, resp_valid in cycle N+5.
REQ-037 Signed/unsigned high-word products SHALL give:
- MULH 0x80000000*0x80000000 -> 0x40000000
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE
- MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF
REQ-038 resp_ready held low 3 cycles in DONE -> resp_data stable, req_ready=0 and busy=1 throughout; IDLE the cycle after resp_ready rises.
REQ-039 kill asserted at CALC step 2 -> resp_valid never rises, req_ready=1 next cycle; a following MUL 2*3 -> 0x00000006.
REQ-040 MULH then MUL, both a=b=0x00010001 -> 0x00000001, then 0x00020001, returned in cycle N+1 with MULT_RESULT_REUSE_EN and N+5 without.
REQ-041 rst pulsed during CALC step 1 -> no response, busy=0, accumulator cleared; the next request computes correctly.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 32x32 multiplier: operation codes,
// FSM state encoding, step count, half-operand width, result-reuse tag layout.
// Ports: none (package only).
package mult_pkg;

  // Width of one signed half-operand (16 data bits plus sign/zero extension).
  localparam int HALF_W = 17;

  // Number of partial-product steps spent in CALC.
  localparam int STEPS = 4;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Key of the most recently computed product. MUL and MULH share signedness,
  // so they share one tag and can reuse each other's 64-bit product.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        a_signed;
    logic        b_signed;
    logic        vld;
  } tag_t;

  function automatic logic op_a_signed(op_e op);
    return (op != OP_MULHU);
  endfunction

  function automatic logic op_b_signed(op_e op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/mult17_booth.sv
// Combinational 17x17 signed radix-4 Booth multiplier.
// Latency: 0 cycles (purely combinational). Backpressure: none.
// Ports: x, y - signed 17-bit operands; p - signed 34-bit product.
module mult17_booth
  import mult_pkg::*;
(
  input  logic signed [HALF_W-1:0]   x,
  input  logic signed [HALF_W-1:0]   y,
  output logic signed [2*HALF_W-1:0] p
);

  // y is sign-extended to an even width (18 bits) and given an implicit
  // zero below bit 0, giving nine overlapping 3-bit Booth groups.
  logic [HALF_W+1:0]   y_ext;
  logic [2*HALF_W-1:0] x_1;
  logic [2*HALF_W-1:0] x_2;
  logic [2*HALF_W-1:0] pp;
  logic [2*HALF_W-1:0] sum;
  logic [2:0]          grp;

  always_comb begin
    y_ext = {y[HALF_W-1], y, 1'b0};
    x_1   = {{HALF_W{x[HALF_W-1]}}, x};
    x_2   = x_1 << 1;
    sum   = '0;
    pp    = '0;
    grp   = '0;
    for (int i = 0; i < (HALF_W + 1) / 2; i++) begin
      grp = y_ext[2*i +: 3];
      case (grp)
        3'b001, 3'b010: pp = x_1;
        3'b011:         pp = x_2;
        3'b100:         pp = '0 - x_2;
        3'b101, 3'b110: pp = '0 - x_1;
        default:        pp = '0;
      endcase
      // Accumulation wraps at 34 bits, which is exact for a 17x17 signed product.
      sum = sum + (pp << (2 * i));
    end
    p = sum;
  end

endmodule

// File: rtl/mult32_seq.sv
// Sequential 32x32 multiplier (MUL/MULH/MULHSU/MULHU) built on one shared 17x17 Booth core.
// Latency: response 5 cycles after accept (1 cycle on a result-reuse hit when MULT_RESULT_REUSE_EN).
// Backpressure: one op in flight; req_ready only in IDLE, result held in DONE until resp_ready.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/req_ready - request handshake; req_op, req_a, req_b carried with it
//   kill                - flush: abandons any in-flight op, blocks same-cycle accept
//   resp_valid/resp_ready, resp_data - result handshake (low word for MUL, high word otherwise)
//   busy                - high whenever the FSM is not IDLE
// Optional feature: define MULT_RESULT_REUSE_EN to keep the last product and
// skip CALC when a new request repeats the same operands and signedness.
module mult32_seq
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        kill,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy
);

  state_e      state;
  state_e      state_nxt;
  logic [1:0]  step;
  logic [63:0] acc;
  logic [31:0] a_q;
  logic [31:0] b_q;
  op_e         op_q;

  logic        accept;
  logic        calc_last;
  logic        reuse_hit;
  logic [63:0] reuse_prod;

  logic a_sgn;
  logic b_sgn;
  logic signed [HALF_W-1:0]   a_lo;
  logic signed [HALF_W-1:0]   a_hi;
  logic signed [HALF_W-1:0]   b_lo;
  logic signed [HALF_W-1:0]   b_hi;
  logic signed [HALF_W-1:0]   mul_x;
  logic signed [HALF_W-1:0]   mul_y;
  logic signed [2*HALF_W-1:0] prod;
  logic [63:0] prod_ext;
  logic [63:0] addend;
  logic [63:0] acc_sum;

  assign accept    = req_valid && (state == ST_IDLE) && !kill;
  assign calc_last = (state == ST_CALC) && (step == 2'(STEPS - 1));

  // ---------------------------------------------------------------------------
  // Result-reuse tag
  // ---------------------------------------------------------------------------
`ifdef MULT_RESULT_REUSE_EN
  tag_t        tag;
  logic [63:0] last_prod;

  assign reuse_hit  = tag.vld
                   && (tag.a == req_a) && (tag.b == req_b)
                   && (tag.a_signed == op_a_signed(op_e'(req_op)))
                   && (tag.b_signed == op_b_signed(op_e'(req_op)));
  assign reuse_prod = last_prod;

  // Captured only on a completed CALC->DONE step, so a kill or reset
  // mid-calculation never stores a partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag       <= '0;
      last_prod <= '0;
    end else if (calc_last && !kill) begin
      tag.a        <= a_q;
      tag.b        <= b_q;
      tag.a_signed <= a_sgn;
      tag.b_signed <= b_sgn;
      tag.vld      <= 1'b1;
      last_prod    <= acc_sum;
    end
  end
`else
  assign reuse_hit  = 1'b0;
  assign reuse_prod = '0;
`endif

  // ---------------------------------------------------------------------------
  // Operand split and shared Booth core
  // ---------------------------------------------------------------------------
  assign a_sgn = op_a_signed(op_q);
  assign b_sgn = op_b_signed(op_q);

  // Low halves are always non-negative; high halves carry the operand's sign
  // only when that operand is treated as signed.
  assign a_lo = {1'b0, a_q[15:0]};
  assign b_lo = {1'b0, b_q[15:0]};
  assign a_hi = {a_sgn & a_q[31], a_q[31:16]};
  assign b_hi = {b_sgn & b_q[31], b_q[31:16]};

  always_comb begin
    mul_x  = a_lo;
    mul_y  = b_lo;
    addend = '0;
    case (step)
      2'd0: begin mul_x = a_lo; mul_y = b_lo; addend = prod_ext;       end
      2'd1: begin mul_x = a_lo; mul_y = b_hi; addend = prod_ext << 16; end
      2'd2: begin mul_x = a_hi; mul_y = b_lo; addend = prod_ext << 16; end
      default: begin mul_x = a_hi; mul_y = b_hi; addend = prod_ext << 32; end
    endcase
  end

  mult17_booth u_booth (
    .x (mul_x),
    .y (mul_y),
    .p (prod)
  );

  assign prod_ext = {{(64 - 2*HALF_W){prod[2*HALF_W-1]}}, prod};
  assign acc_sum  = acc + addend;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt = reuse_hit ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (step == 2'(STEPS - 1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // kill wins over everything; with resp_ready in DONE the transfer still
    // counts as done since both paths land in IDLE.
    if (kill) begin
      state_nxt = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready  = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    resp_valid = (state == ST_DONE);
    resp_data  = '0;
    if (state == ST_DONE) begin
      resp_data = (op_q == OP_MUL) ? acc[31:0] : acc[63:32];
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_MUL;
      step <= '0;
      acc  <= '0;
    end else if (accept) begin
      a_q  <= req_a;
      b_q  <= req_b;
      op_q <= op_e'(req_op);
      step <= '0;
      // A reuse hit goes straight to DONE, so the stored product is loaded here.
      acc  <= reuse_hit ? reuse_prod : '0;
    end else if ((state == ST_CALC) && !kill) begin
      acc  <= acc_sum;
      step <= step + 2'd1;
    end
  end

endmodule

// File: tb/tb_mult32_seq.sv
// Directed self-checking bench for mult32_seq.
// Latency: expected response cycle tracked per request. Backpressure: exercises held resp_ready and kill.
// Ports: none (top-level bench).
module tb_mult32_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        kill;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  int checks;
  int failures;

  localparam logic [1:0] MUL    = 2'd0;
  localparam logic [1:0] MULH   = 2'd1;
  localparam logic [1:0] MULHSU = 2'd2;
  localparam logic [1:0] MULHU  = 2'd3;

`ifdef MULT_RESULT_REUSE_EN
  localparam int REUSE_LAT = 1;
`else
  localparam int REUSE_LAT = 5;
`endif

  mult32_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .kill       (kill),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure cycles until resp_valid (1 = cycle after accept),
  // optionally stall the consumer for 'hold' cycles, then take the result.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input int hold);
    int lat;
    req_op     = op;
    req_a      = a;
    req_b      = b;
    req_valid  = 1'b1;
    resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    lat = 1;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, 64'(resp_data), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_vld"}, 64'(resp_valid), 64'd1);
      check({tag, "_hold_data"}, 64'(resp_data), 64'(exp));
      check({tag, "_hold_rdy"}, 64'(req_ready), 64'd0);
      check({tag, "_hold_busy"}, 64'(busy), 64'd1);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_idle_vld"}, 64'(resp_valid), 64'd0);
    check({tag, "_idle_rdy"}, 64'(req_ready), 64'd1);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int seen;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = MUL;
    req_a      = '0;
    req_b      = '0;
    kill       = 1'b0;
    resp_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 64'(req_ready), 64'd1);

    // Basic products
    do_op("mul_7_m3", MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5, 0);
    do_op("mulh_min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5, 0);
    do_op("mulhu_ff", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 0);
    do_op("mulhsu_ff", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0);
    do_op("mul_m1_m1", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5, 0);
    do_op("mulh_m2_3", MULH, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 5, 0);
    do_op("mulhu_mid", MULHU, 32'h1234_5678, 32'h0001_0000, 32'h0000_1234, 5, 0);

    // Consumer stall in DONE
    do_op("hold3", MUL, 32'h0000_0005, 32'h0000_0006, 32'h0000_001E, 5, 3);

    // kill coinciding with a request in IDLE: no accept
    req_op = MUL; req_a = 32'd9; req_b = 32'd9;
    req_valid = 1'b1;
    kill = 1'b1;
    tick();
    req_valid = 1'b0;
    kill = 1'b0;
    check("kill_idle_busy", 64'(busy), 64'd0);
    check("kill_idle_ready", 64'(req_ready), 64'd1);

    // kill during CALC step 2
    req_op = MUL; req_a = 32'h0000_1111; req_b = 32'h0000_2222;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_calc_ready", 64'(req_ready), 64'd1);
    check("kill_calc_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid) seen = 1;
      tick();
    end
    check("kill_calc_no_resp", 64'(seen), 64'd0);
    do_op("after_kill", MUL, 32'd2, 32'd3, 32'h0000_0006, 5, 0);

    // kill together with resp_ready in DONE
    req_op = MUL; req_a = 32'd4; req_b = 32'd4;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("kd_valid", 64'(resp_valid), 64'd1);
    check("kd_data", 64'(resp_data), 64'd16);
    kill = 1'b1;
    resp_ready = 1'b1;
    tick();
    kill = 1'b0;
    resp_ready = 1'b0;
    check("kd_idle_vld", 64'(resp_valid), 64'd0);
    check("kd_idle_rdy", 64'(req_ready), 64'd1);

    // Same operands and signedness back to back
    do_op("reuse_mulh", MULH, 32'h0001_0001, 32'h0001_0001, 32'h0000_0001, 5, 0);
    do_op("reuse_mul", MUL, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, REUSE_LAT, 0);

    // Reset during CALC step 1
    req_op = MULHU; req_a = 32'hDEAD_BEEF; req_b = 32'h1234_5678;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_calc_busy", 64'(busy), 64'd0);
    check("rst_calc_vld", 64'(resp_valid), 64'd0);
    check("rst_calc_data", 64'(resp_data), 64'd0);
    tick();
    check("rst_calc_ready", 64'(req_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) seen = 1;
      tick();
    end
    check("rst_calc_no_resp", 64'(seen), 64'd0);
    // Tag was cleared by reset, so this repeat takes the full path.
    do_op("after_rst", MUL, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
